ps2_key_gen: RTL and testbench



---
 rtl/ps2_key_gen_if.sv | 11 +
 rtl/ps2_key_gen.sv | 144 ++++++++++++++
 tb/tb_ps2_key_gen.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_gen_if.sv
// Upstream key-event push port for ps2_key_gen: valid/ready handshake carrying scan code, E0 flag and press/release.
interface ps2_key_gen_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_pressed;

    modport master (output ev_valid, ev_code, ev_ext, ev_pressed, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_ext, ev_pressed, output ev_ready);
endinterface

// File: rtl/ps2_key_gen.sv
// Queues key events and replays them onto ps2_key by flipping bit 10, with a fixed idle gap after each event.
// Optional auto-repeat of the last held key is compiled in with `define PS2_KEY_GEN_TYPEMATIC_EN.
module ps2_key_gen #(
    parameter int unsigned FIFO_AW    = 3,
    parameter int unsigned GAP_CYCLES = 16,
    parameter logic [23:0] TM_DELAY   = 24'd12_250_000,
    parameter logic [23:0] TM_RATE    = 24'd1_633_333
) (
    input  logic                clk_sys,
    input  logic                reset,
    ps2_key_gen_if.slave        ev,
    output logic [10:0]         ps2_key,
    output logic                busy,
    output logic [FIFO_AW:0]    fifo_count
);

    localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || TM_DELAY == 24'd0 || TM_RATE == 24'd0) begin : g_bad_param
        $error("ps2_key_gen: GAP_CYCLES must be 1..255 and TM_DELAY/TM_RATE non-zero");
    end

    typedef enum logic [1:0] {
        IDLE,
        GAP
`ifdef PS2_KEY_GEN_TYPEMATIC_EN
        , REPEAT
`endif
    } state_t;

    logic [9:0]         mem [0:(1 << FIFO_AW) - 1];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_nx;
    logic               ready_q;
    state_t             state, state_nx;
    logic [7:0]         gap_cnt;
    logic               push, pop, emit;
    logic [9:0]         emit_data;

    assign push        = ev.ev_valid && ready_q;
    assign ev.ev_ready = ready_q && reset;
    assign busy        = (count != '0) || (state != IDLE);
    assign fifo_count  = count;

`ifdef PS2_KEY_GEN_TYPEMATIC_EN
    logic [8:0]  held;
    logic        held_v;
    logic [23:0] tm_cnt;
    logic        tm_due;

    // Due two counts early: one edge to enter REPEAT, one to emit, so repeats land exactly TM_* edges apart.
    assign tm_due = held_v && (tm_cnt <= 24'd2);

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            held   <= '0;
            held_v <= 1'b0;
            tm_cnt <= '0;
        end else if (emit && emit_data[9]) begin
            held   <= emit_data[8:0];
            held_v <= 1'b1;
            tm_cnt <= (state == REPEAT) ? TM_RATE : TM_DELAY;
        end else begin
            if (emit && held_v && emit_data[8:0] == held)
                held_v <= 1'b0;
            if (tm_cnt != '0)
                tm_cnt <= tm_cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        emit      = 1'b0;
        emit_data = mem[rd_ptr];
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    emit     = 1'b1;
                    state_nx = GAP;
                end
`ifdef PS2_KEY_GEN_TYPEMATIC_EN
                else if (tm_due) begin
                    state_nx = REPEAT;
                end
`endif
            end
            GAP: begin
                if (gap_cnt == 8'd1)
                    state_nx = IDLE;
            end
`ifdef PS2_KEY_GEN_TYPEMATIC_EN
            REPEAT: begin
                emit      = 1'b1;
                emit_data = {1'b1, held};
                state_nx  = GAP;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        count_nx = count;
        if (push && !pop)
            count_nx = count + 1'b1;
        else if (pop && !push)
            count_nx = count - 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr] <= {ev.ev_pressed, ev.ev_ext, ev.ev_code};
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            gap_cnt <= '0;
            ps2_key <= '0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            ready_q <= (count_nx != FULL);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (emit) begin
                ps2_key <= {~ps2_key[10], emit_data};
                gap_cnt <= 8'(GAP_CYCLES);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Bench for ps2_key_gen: event-timeline reference model (queue + emission times) checked every cycle.
module tb_ps2_key_gen;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int GAP   = 16;
    localparam int TMD   = 100;
    localparam int TMR   = 40;
`ifdef PS2_KEY_GEN_TYPEMATIC_EN
    localparam bit TYP = 1'b1;
`else
    localparam bit TYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [10:0]   key;
    logic          busy;
    logic [AW:0]   fcnt;

    ps2_key_gen_if bus ();

    ps2_key_gen #(
        .FIFO_AW   (AW),
        .GAP_CYCLES(GAP),
        .TM_DELAY  (24'(TMD)),
        .TM_RATE   (24'(TMR))
    ) dut (
        .clk_sys   (clk),
        .reset     (rst),
        .ev        (bus.slave),
        .ps2_key   (key),
        .busy      (busy),
        .fifo_count(fcnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: FIFO contents, next edge at which an emission may start, typematic schedule.
    int         cyc = 0;
    int         free_at = 0;
    int         due_at = 0;
    int         rep_at = 0;
    bit         rep_pending = 0;
    bit         held_v = 0;
    logic [8:0] held = '0;
    logic [10:0] m_key = '0;
    bit         m_ready = 0;
    bit         m_acc = 0;
    logic [9:0] q[$];

    int          tog_t[$];
    logic [10:0] tog_v[$];
    logic        prev_tog = 1'b0;

    function automatic void model_emit(input logic [9:0] d, input bit is_rep);
        m_key   = {~m_key[10], d};
        free_at = cyc + GAP + 1;
        if (d[9]) begin
            held   = d[8:0];
            held_v = 1'b1;
            due_at = cyc + (is_rep ? TMR : TMD);
        end else if (held_v && held == d[8:0]) begin
            held_v = 1'b0;
        end
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_ready && rst, (q.size() != 0) || (cyc < free_at - 1), 4'(q.size()), m_key};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {bus.ev_ready, busy, fcnt, key};
    endfunction

    task automatic tick();
        bit v, r;
        logic [9:0] d;
        v = bus.ev_valid;
        r = rst;
        d = {bus.ev_pressed, bus.ev_ext, bus.ev_code};
        @(posedge clk);
        cyc++;
        m_acc = 1'b0;
        if (!r) begin
            q.delete();
            m_key       = '0;
            m_ready     = 1'b0;
            free_at     = cyc + 1;
            held_v      = 1'b0;
            rep_pending = 1'b0;
        end else begin
            m_acc = v && m_ready;
            if (rep_pending && rep_at == cyc) begin
                rep_pending = 1'b0;
                model_emit({1'b1, held}, 1'b1);
            end else if (cyc >= free_at && q.size() != 0) begin
                model_emit(q.pop_front(), 1'b0);
            end else if (TYP && cyc >= free_at && held_v && cyc >= due_at - 1) begin
                rep_pending = 1'b1;
                rep_at      = cyc + 1;
                free_at     = cyc + 2 + GAP;
            end
            if (m_acc)
                q.push_back(d);
            m_ready = (q.size() != DEPTH);
        end
        #1;
        if (key[10] !== prev_tog) begin
            tog_t.push_back(cyc);
            tog_v.push_back(key);
            prev_tog = key[10];
        end
    endtask

    task automatic feed(input bit have, input logic [9:0] head);
        bus.ev_valid = have;
        {bus.ev_pressed, bus.ev_ext, bus.ev_code} = head;
    endtask

    task automatic clear_toggles();
        tog_t.delete();
        tog_v.delete();
        prev_tog = key[10];
    endtask

    task automatic do_reset();
        feed(1'b0, '0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        clear_toggles();
    endtask

    task automatic test_reset();
        feed(1'b0, '0);
        rst = 1'b0;
        tick();
        vectors++;
        if (obs_vec() !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), 17'h0);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== {1'b1, 1'b0, 4'd0, 11'h000}) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", obs_vec(), {1'b1, 1'b0, 4'd0, 11'h000});
        end
        clear_toggles();
    endtask

    task automatic test_latency();
        int fall = -1;
        do_reset();
        feed(1'b1, {1'b1, 1'b0, 8'h16});
        tick();
        feed(1'b0, '0);
        for (int i = 1; i <= 40; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL latency_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                vectors++;
                if (key !== 11'h616) begin
                    miscompares++;
                    $display("FAIL latency_key: got %h expected %h", key, 11'h616);
                end
            end
            if (busy === 1'b0 && fall < 0)
                fall = i;
        end
        vectors++;
        if (fall != 17) begin
            miscompares++;
            $display("FAIL busy_fall: got %0d expected %0d", fall, 17);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] items[$];
        do_reset();
        items.push_back({1'b1, 1'b0, 8'h16});
        items.push_back({1'b0, 1'b0, 8'h16});
        for (int i = 0; i < 60; i++) begin
            feed(items.size() != 0, items.size() != 0 ? items[0] : 10'h0);
            tick();
            if (m_acc)
                void'(items.pop_front());
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (tog_t.size() != 2 || tog_v[0] !== 11'h616 || tog_v[1] !== 11'h016 || tog_t[1] - tog_t[0] != GAP + 1) begin
            miscompares++;
            $display("FAIL b2b_events: got %0d toggles first=%h second=%h gap=%0d expected 2 toggles 616 016 gap %0d",
                     tog_t.size(), tog_v.size() > 0 ? tog_v[0] : 11'hx, tog_v.size() > 1 ? tog_v[1] : 11'hx,
                     tog_t.size() > 1 ? tog_t[1] - tog_t[0] : -1, GAP + 1);
        end
    endtask

    task automatic test_fill();
        logic [9:0] items[$];
        int acc = 0;
        do_reset();
        for (int i = 0; i < 10; i++)
            items.push_back({2'b00, 8'(8'h20 + i)});
        for (int i = 0; i < 200; i++) begin
            feed(items.size() != 0, items.size() != 0 ? items[0] : 10'h0);
            tick();
            if (m_acc) begin
                void'(items.pop_front());
                acc++;
                if (acc == 9) begin
                    vectors++;
                    if ({bus.ev_ready, fcnt} !== {1'b0, 4'd8}) begin
                        miscompares++;
                        $display("FAIL fill_full: got ready=%b count=%0d expected ready=0 count=8", bus.ev_ready, fcnt);
                    end
                end
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fill_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (tog_t.size() != 10) begin
            miscompares++;
            $display("FAIL fill_count: got %0d expected %0d", tog_t.size(), 10);
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (tog_v[i][9:0] !== {2'b00, 8'(8'h20 + i)} || (i > 0 && tog_t[i] - tog_t[i-1] != GAP + 1)) begin
                    miscompares++;
                    $display("FAIL fill_order[%0d]: got %h at spacing %0d expected %h at spacing %0d", i, tog_v[i][9:0],
                             i > 0 ? tog_t[i] - tog_t[i-1] : 0, {2'b00, 8'(8'h20 + i)}, GAP + 1);
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        logic [9:0] items[$];
        do_reset();
        for (int i = 0; i < 6; i++)
            items.push_back({2'b00, 8'(8'h40 + i)});
        for (int i = 0; i < 20 && items.size() != 0; i++) begin
            feed(1'b1, items[0]);
            tick();
            if (m_acc)
                void'(items.pop_front());
        end
        vectors++;
        if (fcnt !== 4'd5) begin
            miscompares++;
            $display("FAIL midburst_queued: got %0d expected %0d", fcnt, 5);
        end
        feed(1'b0, '0);
        rst = 1'b0;
        tick();
        vectors++;
        if (obs_vec() !== 17'h0) begin
            miscompares++;
            $display("FAIL midburst_reset: got %h expected %h", obs_vec(), 17'h0);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== {1'b1, 1'b0, 4'd0, 11'h000}) begin
            miscompares++;
            $display("FAIL midburst_release: got %h expected %h", obs_vec(), {1'b1, 1'b0, 4'd0, 11'h000});
        end
        clear_toggles();
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL midburst_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (tog_t.size() != 0) begin
            miscompares++;
            $display("FAIL midburst_quiet: got %0d toggles expected 0", tog_t.size());
        end
    endtask

    task automatic test_typematic();
        logic [9:0] items[$];
        int exp_n;
        do_reset();
        items.push_back({1'b1, 1'b1, 8'h75});
        for (int i = 0; i < 380; i++) begin
            if (i == 230)
                items.push_back({1'b0, 1'b1, 8'h75});
            feed(items.size() != 0, items.size() != 0 ? items[0] : 10'h0);
            tick();
            if (m_acc)
                void'(items.pop_front());
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL typematic_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        exp_n = TYP ? 6 : 2;
        vectors++;
        if (tog_t.size() != exp_n || tog_v[0] !== 11'h775 || key !== 11'h175) begin
            miscompares++;
            $display("FAIL typematic_events: got %0d toggles first=%h final=%h expected %0d toggles 775 175",
                     tog_t.size(), tog_v.size() > 0 ? tog_v[0] : 11'hx, key, exp_n);
        end else if (TYP) begin
            for (int i = 1; i <= 4; i++) begin
                vectors++;
                if (tog_t[i] - tog_t[i-1] != (i == 1 ? TMD : TMR) || tog_v[i][9:0] !== 10'h375) begin
                    miscompares++;
                    $display("FAIL typematic_repeat[%0d]: got delta %0d key %h expected delta %0d key 375",
                             i, tog_t[i] - tog_t[i-1], tog_v[i][9:0], i == 1 ? TMD : TMR);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] codes[4];
        codes[0] = 8'h16; codes[1] = 8'h1c; codes[2] = 8'h75; codes[3] = 8'h2a;
        do_reset();
        m_acc = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if (!bus.ev_valid || m_acc)
                feed($urandom_range(0, 3) == 0, {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                                 codes[$urandom_range(0, 3)]});
            rst = ($urandom_range(0, 299) != 0);
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        feed(1'b0, '0);
        test_reset();
        test_latency();
        test_back_to_back();
        test_fill();
        test_reset_midburst();
        test_typematic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
